reg_fetch: RTL
==============

REG_FETCH -- requirements
Module: reg_fetch

Interface
REQ-001 Parameters: none; register count fixed at 128, data width fixed at 128 bits, big-endian bit numbering [0:N].
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-low reset; sampled at posedge clk, asserted when 0.
REQ-004 in_valid  in  1  upstream decoded instruction valid.
REQ-005 in_ready  out  1  block can accept the instruction this cycle; combinational; independent of in_valid.
REQ-006 in_op  in  11  opcode, truncated per format.
REQ-007 in_format  in  3  instruction format code, 0..6.
REQ-008 in_ra_addr, in_rb_addr, in_rt_addr  in  7 each  source A, source B and destination register addresses.
REQ-009 in_ra_used, in_rb_used  in  1 each  instruction reads source A / source B.
REQ-010 in_imm  in  18  immediate, truncated per format.
REQ-011 in_reg_write  in  1  instruction writes its destination.
REQ-012 op, format, rt_addr, imm, reg_write  out  11/3/7/18/1  registered issue fields to the execution unit.
REQ-013 ra, rb  out  128 each  registered source operand values to the execution unit.
REQ-014 wb_data  in  128; wb_addr  in  7; wb_we  in  1  write-back port from the execution unit.

Function
REQ-015 Hold a 128 x 128-bit register file; one write port (wb_*), two read ports (in_ra_addr, in_rb_addr).
REQ-016 When wb_we=1, write wb_data into entry wb_addr at posedge clk.
REQ-017 Read ports are combinational with write-first bypass: wb_we=1 and wb_addr equal to a read address returns wb_data, not the stored value.
REQ-018 Keep a 128-bit pending scoreboard with one bit per register.
REQ-019 hazard = (in_ra_used & pend[ra] & !wbhit(ra)) | (in_rb_used & pend[rb] & !wbhit(rb)) | (in_reg_write & pend[rt] & !wbhit(rt)); wbhit(x) = wb_we & (wb_addr==x).
REQ-020 in_ready = !hazard.
REQ-021 Issue occurs on a cycle with in_valid=1 and in_ready=1; the instruction is accepted at that posedge.
REQ-022 On issue, register on that posedge: op=in_op, format=in_format, rt_addr=in_rt_addr, imm=in_imm, reg_write=in_reg_write, ra/rb=bypassed read values; latency 1 cycle.
REQ-023 On a posedge without issue (stall or in_valid=0), drive a nop on that posedge: all issue outputs 0; the execution unit treats format=0/op=0 as nop.
REQ-024 An unused source (in_*_used=0) still drives the read value on ra/rb; it does not take part in hazard detection.
REQ-025 Scoreboard update at posedge: clear pend[wb_addr] if wb_we; then set pend[in_rt_addr] on issue with in_reg_write=1; set wins if both target the same address.
REQ-026 The WAW check in REQ-019 limits each register to at most one outstanding write; a write-back to a non-pending register still updates the register file.
REQ-027 No reordering, no buffering: a stalled instruction is held by upstream and re-evaluated every cycle.

Reset
REQ-028 When reset=0 at posedge: clear all 128 register entries to 0, clear all pend bits, drive all issue outputs 0.
REQ-029 Reset wins over a simultaneous issue or write-back in the same cycle; in-flight instructions are dropped; in_ready=1 after the reset cycle (scoreboard empty).

Verification
REQ-030 Reset, then wb_we=1 with wb_addr=5 and wb_data=all-0xA5; next cycle issue ra=5 with ra_used=1 -> ra output = all-0xA5 one cycle after issue.
REQ-031 Issue rt=3 with reg_write=1; next cycle present ra=3 with ra_used=1 -> in_ready=0 and nop outputs until the cycle wb_we=1, wb_addr=3; in that cycle in_ready=1 and ra = wb_data (bypass).
REQ-032 Issue rt=7 with reg_write=1, then an instruction with rt=7 and reg_write=1, ra/rb unused -> stalled (WAW) until write-back of 7; after that it issues and pend[7] stays 1.
REQ-033 in_ra_used=0 with ra=3 pending, rb=9 not pending -> no stall; the instruction issues immediately.
REQ-034 Stall for 3 cycles, then drive reset=0 for one cycle -> all outputs 0, registers read 0, in_ready=1 next cycle.
REQ-035 Same-cycle wb_we to addr 4 and issue with rt=4 (4 not pending) -> pend[4]=1 after the edge; register 4 holds wb_data.

Source files
------------

// File: rtl/reg_fetch.sv
// ----------------------------------------------------------------------------
// reg_fetch
//
// Register-fetch stage between the instruction decoder and the execution
// unit. Holds a 128 x 128-bit register file and a pending-write scoreboard,
// stalls on RAW/WAW hazards and issues one instruction per cycle with its
// operand values registered alongside the decoded fields.
//
// Ports
//   clk            sole clock, all state updates on its rising edge
//   reset          synchronous, active-low
//   in_valid       decoded instruction present
//   in_ready       instruction can be accepted this cycle (combinational)
//   in_op          opcode                      [0:10]
//   in_format      instruction format          [0:2]
//   in_ra_addr     source A register address   [0:6]
//   in_rb_addr     source B register address   [0:6]
//   in_rt_addr     destination register        [0:6]
//   in_ra_used     instruction reads source A
//   in_rb_used     instruction reads source B
//   in_imm         immediate                   [0:17]
//   in_reg_write   instruction writes its destination
//   op/format/rt_addr/imm/reg_write   registered issue fields (all 0 = nop)
//   ra/rb          registered source operand values [0:127]
//   wb_data        write-back data             [0:127]
//   wb_addr        write-back address          [0:6]
//   wb_we          write-back enable
// ----------------------------------------------------------------------------
module reg_fetch (
    input  logic         clk,
    input  logic         reset,

    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:10]  in_op,
    input  logic [0:2]   in_format,
    input  logic [0:6]   in_ra_addr,
    input  logic [0:6]   in_rb_addr,
    input  logic [0:6]   in_rt_addr,
    input  logic         in_ra_used,
    input  logic         in_rb_used,
    input  logic [0:17]  in_imm,
    input  logic         in_reg_write,

    output logic [0:10]  op,
    output logic [0:2]   format,
    output logic [0:6]   rt_addr,
    output logic [0:17]  imm,
    output logic         reg_write,
    output logic [0:127] ra,
    output logic [0:127] rb,

    input  logic [0:127] wb_data,
    input  logic [0:6]   wb_addr,
    input  logic         wb_we
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:127] r_rf [0:127];
    logic [0:127] r_pend;

    logic [0:10]  r_op;
    logic [0:2]   r_format;
    logic [0:6]   r_rt_addr;
    logic [0:17]  r_imm;
    logic         r_reg_write;
    logic [0:127] r_ra;
    logic [0:127] r_rb;

    // ------------------------------------------------------------------
    // Read ports with write-first bypass
    // ------------------------------------------------------------------
    logic         w_hit_ra;
    logic         w_hit_rb;
    logic         w_hit_rt;
    logic [0:127] w_ra_val;
    logic [0:127] w_rb_val;

    assign w_hit_ra = wb_we && (wb_addr == in_ra_addr);
    assign w_hit_rb = wb_we && (wb_addr == in_rb_addr);
    assign w_hit_rt = wb_we && (wb_addr == in_rt_addr);

    assign w_ra_val = w_hit_ra ? wb_data : r_rf[in_ra_addr];
    assign w_rb_val = w_hit_rb ? wb_data : r_rf[in_rb_addr];

    // ------------------------------------------------------------------
    // Hazard detection
    // A pending register whose write-back lands this very cycle is not a
    // hazard: the bypass supplies the value and the scoreboard bit clears
    // on the same edge, so the instruction may proceed.
    // ------------------------------------------------------------------
    logic w_haz_ra;
    logic w_haz_rb;
    logic w_haz_rt;
    logic w_hazard;
    logic w_issue;

    assign w_haz_ra = in_ra_used   && r_pend[in_ra_addr] && !w_hit_ra;
    assign w_haz_rb = in_rb_used   && r_pend[in_rb_addr] && !w_hit_rb;
    assign w_haz_rt = in_reg_write && r_pend[in_rt_addr] && !w_hit_rt;
    assign w_hazard = w_haz_ra || w_haz_rb || w_haz_rt;

    assign in_ready = !w_hazard;
    assign w_issue  = in_valid && !w_hazard;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 128; i++) begin
                r_rf[i] <= '0;
            end
        end else if (wb_we) begin
            r_rf[wb_addr] <= wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // The set is written after the clear so that a same-cycle write-back
    // and issue to one address leaves the bit set: the new write is the
    // one still outstanding.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pend <= '0;
        end else begin
            if (wb_we) begin
                r_pend[wb_addr] <= 1'b0;
            end
            if (w_issue && in_reg_write) begin
                r_pend[in_rt_addr] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue register; a cycle without issue presents an all-zero nop
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset || !w_issue) begin
            r_op        <= '0;
            r_format    <= '0;
            r_rt_addr   <= '0;
            r_imm       <= '0;
            r_reg_write <= 1'b0;
            r_ra        <= '0;
            r_rb        <= '0;
        end else begin
            r_op        <= in_op;
            r_format    <= in_format;
            r_rt_addr   <= in_rt_addr;
            r_imm       <= in_imm;
            r_reg_write <= in_reg_write;
            r_ra        <= w_ra_val;
            r_rb        <= w_rb_val;
        end
    end

    assign op        = r_op;
    assign format    = r_format;
    assign rt_addr   = r_rt_addr;
    assign imm       = r_imm;
    assign reg_write = r_reg_write;
    assign ra        = r_ra;
    assign rb        = r_rb;

endmodule
